// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: size codes, FSM states, defaults.
package mem_access_unit_pkg;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] SWHB_W = 2'b01;
  localparam logic [1:0] SWHB_H = 2'b10;
  localparam logic [1:0] SWHB_B = 2'b11;

  localparam logic [1:0] LWHB_W = 2'b00;
  localparam logic [1:0] LWHB_H = 2'b01;
  localparam logic [1:0] LWHB_B = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BAD} size_e;

  // Store and load size fields use different encodings; fold both onto size_e.
  function automatic size_e decode_size(input logic is_store, input logic [1:0] swhb,
                                        input logic [1:0] lwhb);
    size_e sz;
    sz = SZ_BAD;
    if (is_store) begin
      case (swhb)
        SWHB_W:  sz = SZ_WORD;
        SWHB_H:  sz = SZ_HALF;
        SWHB_B:  sz = SZ_BYTE;
        default: sz = SZ_BAD;
      endcase
    end else begin
      case (lwhb)
        LWHB_W:  sz = SZ_WORD;
        LWHB_H:  sz = SZ_HALF;
        LWHB_B:  sz = SZ_BYTE;
        default: sz = SZ_BAD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replication, fault detection, load extract/extend.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  size_e       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  input  size_e       ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_wdata_i;
    fault_o = 1'b0;
    case (st_size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_wdata_i[15:0]}};
        fault_o = st_off_i[0];
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        fault_o = |st_off_i;
      end
      default: fault_o = 1'b1;
    endcase
  end

  assign shifted = ld_word_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one op becomes one word-aligned bus beat; stalls until done, fault or timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              memwrite_i,
  input  logic              memtoreg_i,
  input  logic [1:0]        swhb_i,
  input  logic [1:0]        lwhb_i,
  input  logic              lunsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  size_e             ld_size_q, ld_size_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              ld_uns_q, ld_uns_d;

  logic              accept;
  size_e             req_size;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       ld_data;
  logic              fault;

  assign accept   = valid_i & (memwrite_i | memtoreg_i) & ~flush_i;
  assign req_size = decode_size(memwrite_i, swhb_i, lwhb_i);

  mem_lane_align u_align (
    .st_size_i     (req_size),
    .st_off_i      (addr_i[1:0]),
    .st_wdata_i    (wdata_i),
    .be_o          (lane_be),
    .wdata_o       (lane_wdata),
    .fault_o       (fault),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_word_i     (bus_rdata_i),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_size_d   = ld_size_q;
    ld_off_d    = ld_off_q;
    ld_uns_d    = ld_uns_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          kill_d = 1'b0;
          if (fault) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            err_d       = 1'b0;
            bus_we_d    = memwrite_i;
            bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_d    = lane_be;
            bus_wdata_d = lane_wdata;
            ld_size_d   = req_size;
            ld_off_d    = addr_i[1:0];
            ld_uns_d    = lunsigned_i;
            cnt_d       = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A flushed op still finishes its bus beat, but leaves no trace upstream.
        kill_d = kill_q | flush_i;
        if (bus_ready_i) begin
          state_d = kill_d ? ST_IDLE : ST_RESP;
          if (!kill_d) rdata_d = bus_we_q ? 32'h0 : ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = kill_d ? ST_IDLE : ST_RESP;
          if (!kill_d) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      ld_size_q   <= SZ_WORD;
      ld_off_q    <= '0;
      ld_uns_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_uns_q    <= ld_uns_d;
    end
  end

  assign stall_o     = ((state_q == ST_IDLE) & accept) | (state_q == ST_REQ);
  assign done_o      = (state_q == ST_RESP) & ~flush_i;
  assign err_o       = done_o & err_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = (state_q == ST_REQ);
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a spec-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam int NONE = 99;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0, memwrite_i = 1'b0, memtoreg_i = 1'b0;
  logic [1:0]  swhb_i = 2'b00, lwhb_i = 2'b00;
  logic        lunsigned_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, done_o, err_o, bus_req_o, bus_we_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ready_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
    .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i), .swhb_i(swhb_i), .lwhb_i(lwhb_i),
    .lunsigned_i(lunsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  mon_b;
  resp_t mon_r;
  logic  req_prev = 1'b0;
  logic [31:0] model_rdata = '0;
  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the expectation queues.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus_req_o && !req_prev) begin
        check1("stall_in_req", stall_o, 1'b1);
        checks++;
        if (bus_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: bus_req with no pending request expected (t=%0t)", $time);
        end else begin
          mon_b = bus_q.pop_front();
          check1("bus_we", bus_we_o, mon_b.we);
          check("bus_addr", bus_addr_o, mon_b.addr);
          check("bus_be", 32'(bus_be_o), 32'(mon_b.be));
          if (mon_b.we) check("bus_wdata", bus_wdata_o, mon_b.wdata);
        end
      end
      if (done_o) begin
        check1("stall_on_done", stall_o, 1'b0);
        checks++;
        if (resp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done with no pending response expected (t=%0t)", $time);
        end else begin
          mon_r = resp_q.pop_front();
          check1("err", err_o, mon_r.err);
          check("rdata", rdata_o, mon_r.rdata);
        end
      end else begin
        check1("err_without_done", err_o, 1'b0);
      end
    end
    req_prev <= bus_req_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_op(input logic mw, input logic mr, input logic [1:0] sw, input logic [1:0] lw,
                       input logic lu, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input int d, input int fk,
                       input logic fidle, input logic fresp);
    int          o, sz, last, k;
    logic        is_st, accepted, legal, tmo, killed, has_resp;
    logic [31:0] v, ld, exp_rd, ewd;
    logic [3:0]  ebe;
    bus_t        b;
    resp_t       r;
    is_st = mw;
    o     = int'(a[1:0]);
    // sizes: 0 word, 1 half, 2 byte, 3 illegal
    if (is_st) sz = (sw == 2'b01) ? 0 : (sw == 2'b10) ? 1 : (sw == 2'b11) ? 2 : 3;
    else       sz = (lw == 2'b00) ? 0 : (lw == 2'b01) ? 1 : (lw == 2'b10) ? 2 : 3;
    legal    = (sz == 2) || (sz == 1 && (o % 2) == 0) || (sz == 0 && o == 0);
    accepted = (mw | mr) & ~fidle;
    tmo      = (d >= TO);
    last     = tmo ? TO - 1 : d;
    killed   = accepted && legal && (fk <= last);
    has_resp = accepted && !killed;
    ebe = (sz == 0) ? 4'hF : (sz == 1) ? ((o >= 2) ? 4'hC : 4'h3) : 4'(1 << o);
    ewd = (sz == 2) ? {4{wd[7:0]}} : (sz == 1) ? {2{wd[15:0]}} : wd;
    v   = rw >> (8 * o);
    if (sz == 2)      ld = lu ? {24'h0, v[7:0]} : 32'($signed(v[7:0]));
    else if (sz == 1) ld = lu ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
    else              ld = rw;
    exp_rd = (legal && !is_st && !tmo) ? ld : 32'h0;

    if (accepted && legal) begin
      b.we = is_st; b.addr = {a[31:2], 2'b00}; b.be = ebe; b.wdata = ewd;
      bus_q.push_back(b);
    end
    if (has_resp && !fresp) begin
      r.err = !legal || tmo; r.rdata = exp_rd;
      resp_q.push_back(r);
    end
    if (has_resp) model_rdata = exp_rd;

    valid_i = 1'b1; memwrite_i = mw; memtoreg_i = mr; swhb_i = sw; lwhb_i = lw;
    lunsigned_i = lu; addr_i = a; wdata_i = wd; flush_i = fidle;
    bus_ready_i = 1'($urandom_range(0, 1)); bus_rdata_i = $urandom;
    #1;
    check1("stall_accept", stall_o, accepted);
    tick();
    valid_i = 1'b0; flush_i = 1'b0; bus_ready_i = 1'b0;
    k = 0;
    if (accepted && legal) begin
      while (bus_req_o && k < TO + 2) begin
        bus_ready_i = (k == d);
        bus_rdata_i = (k == d) ? rw : $urandom;
        flush_i     = (k == fk);
        tick();
        k++;
      end
      bus_ready_i = 1'b0; flush_i = 1'b0;
      check("req_cycles", k, tmo ? TO : d + 1);
    end else begin
      check1("no_req", bus_req_o, 1'b0);
    end
    if (has_resp) begin
      flush_i = fresp;
      #1;
      check1("done_pulse", done_o, !fresp);
      check1("stall_in_resp", stall_o, 1'b0);
      tick();
      flush_i = 1'b0;
    end else begin
      check1("no_done", done_o, 1'b0);
    end
    check("rdata_hold", rdata_o, model_rdata);
    repeat ($urandom_range(0, 2)) begin
      bus_ready_i = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
      tick();
    end
    bus_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check1("rst_stall", stall_o, 1'b0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check1("rst_bus_req", bus_req_o, 1'b0);
    check1("rst_bus_we", bus_we_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_bus_addr", bus_addr_o, 32'h0);
    check("rst_bus_be", 32'(bus_be_o), 32'h0);
    check("rst_bus_wdata", bus_wdata_o, 32'h0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // sw, sb, lb/lbu/lh, misaligned lw, illegal store size
    do_op(1, 0, 2'b01, 2'b00, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, NONE, 0, 0);
    do_op(1, 0, 2'b11, 2'b00, 0, 32'h203, 32'h000000A5, 32'h0, 1, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b10, 0, 32'h102, 32'h0, 32'h12F08000, 0, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b10, 1, 32'h102, 32'h0, 32'h12F08000, 2, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b01, 0, 32'h102, 32'h0, 32'h12F08000, 0, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b00, 0, 32'h106, 32'h0, 32'h0, 0, NONE, 0, 0);
    do_op(1, 0, 2'b00, 2'b00, 0, 32'h100, 32'h1234, 32'h0, 0, NONE, 0, 0);
    // timeout, ready on last legal cycle, flush during REQ, flush in RESP, flush in IDLE
    do_op(0, 1, 2'b00, 2'b00, 0, 32'h400, 32'h0, 32'h55AA55AA, 10, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b00, 0, 32'h404, 32'h0, 32'hCAFEF00D, TO - 1, NONE, 0, 0);
    do_op(0, 1, 2'b00, 2'b00, 0, 32'h408, 32'h0, 32'h11111111, 3, 0, 0, 0);
    do_op(0, 1, 2'b00, 2'b01, 1, 32'h40E, 32'h0, 32'h8001ABCD, 1, NONE, 0, 1);
    do_op(1, 0, 2'b01, 2'b00, 0, 32'h500, 32'h77, 32'h0, 0, NONE, 1, 0);
    do_op(1, 1, 2'b10, 2'b00, 0, 32'h502, 32'hBEEF1234, 32'h0, 0, NONE, 0, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 5)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : NONE,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    check("bus_q_drained", bus_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    // async reset while a load is in REQ
    begin
      bus_t b;
      b.we = 1'b0; b.addr = 32'h300; b.be = 4'hF; b.wdata = 32'h0;
      bus_q.push_back(b);
      valid_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1; lwhb_i = 2'b00;
      addr_i = 32'h300; bus_ready_i = 1'b0;
      tick();
      valid_i = 1'b0;
      tick();
      check1("req_before_reset", bus_req_o, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check1("arst_bus_req", bus_req_o, 1'b0);
      check1("arst_stall", stall_o, 1'b0);
      check1("arst_done", done_o, 1'b0);
      check1("arst_err", err_o, 1'b0);
      check1("arst_bus_we", bus_we_o, 1'b0);
      check("arst_bus_addr", bus_addr_o, 32'h0);
      check("arst_bus_be", 32'(bus_be_o), 32'h0);
      check("arst_bus_wdata", bus_wdata_o, 32'h0);
      check("arst_rdata", rdata_o, 32'h0);
      check("arst_bus_q", bus_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine; it is the consumer end of the memwrite/memtoreg/swhb/lwhb/lunsigned control bundle that the decode controller produces.
- Turns one pipeline memory op into a single-beat, word-aligned request on the data bus (req/ready handshake).
- Performs byte-lane steering for stores and extract/extend for loads.
- Stalls the pipeline until the op completes, faults or times out.

Parameters:
- TIMEOUT, 255, max cycles to wait for bus_ready before aborting; counter width = $clog2(TIMEOUT+1).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid  in  1  MEM-stage op present; pipeline holds all inputs stable while stall=1
- flush  in  1  synchronous kill of current op
- memwrite  in  1  store op; has priority if memtoreg also set
- memtoreg  in  1  load op
- swhb  in  2  store size: 01 word, 10 half, 11 byte, 00 illegal
- lwhb  in  2  load size: 00 word, 01 half, 10 byte, 11 illegal
- lunsigned  in  1  zero-extend load
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze upstream stages
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid with done
- err  out  1  one-cycle fault pulse (misaligned, illegal size, timeout)
- bus_req  out  1  request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  transfer accepted/completed this cycle
- bus_rdata  in  32  read word, valid when bus_ready & ~bus_we

Behaviour:
- Reset (reset=0, async): state=IDLE; stall, done, err, bus_req, bus_we = 0; rdata, bus_addr, bus_be, bus_wdata, timeout counter = 0.
- FSM states IDLE, REQ, RESP.
- IDLE, accept = valid & (memwrite|memtoreg) & ~flush:
  - Illegal size or misalignment (half with addr[0]=1; word with addr[1:0]!=0): no bus access; go to RESP with err flagged.
  - Otherwise register bus_addr/bus_be/bus_wdata/bus_we and the load size/sign/offset, set bus_req=1, clear counter, go to REQ.
- REQ: bus_req, bus_addr, bus_be, bus_wdata, bus_we held constant.
  - On bus_ready: deassert bus_req; capture the extended load value; go to RESP.
  - Otherwise increment counter; when it reaches TIMEOUT, deassert bus_req, flag err, go to RESP.
- RESP: done=1 for exactly one cycle (err=1 in the same cycle if flagged); rdata valid this cycle and then held; next state IDLE.
- stall = (state==IDLE & accept) | (state==REQ). It is 0 in RESP, so upstream advances on the done cycle.
- Latency: accept at cycle 0, bus_req from cycle 1; with bus_ready at cycle 1, done at cycle 2. Minimum 2 cycles; fault path 1 cycle (done at cycle 1).
- Store lanes, o = addr[1:0]:
  - byte: be = 4'b0001<<o; wdata = {4{wdata[7:0]}}
  - half: be = o[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}
  - word: be = 1111
- Load extract: v = bus_rdata >> (8*o). Byte uses v[7:0], half uses v[15:0]; sign- or zero-extend per lunsigned; word passes through. For a failed or store op, rdata = 0.
- Loads drive bus_be per size, same as stores.
- flush:
  - In IDLE: nothing is accepted.
  - In REQ: the bus handshake is NOT abandoned; bus_req stays asserted until bus_ready or timeout, but a sticky kill flag suppresses done, err and the rdata update. The FSM returns directly to IDLE.
  - In RESP: done/err are suppressed.
- bus_ready outside REQ is ignored.
- Back-to-back ops: IDLE is re-entered after RESP, so the maximum rate is one op per 3 cycles.

Decomposition:
- Shared package/defines file: swhb/lwhb encodings (SWHB_W/H/B, LWHB_W/H/B), FSM state encodings, TIMEOUT default.
- One sub-module, mem_lane_align (combinational): store be/wdata generation, load extract/extend, misalign/illegal detection. Reused by the future I-cache/uncached path.

Test Plan:
- sw addr=0x104, wdata=0xDEADBEEF, bus_ready at 1st req cycle -> bus_addr=0x104, be=1111, we=1, done at cycle 2, err=0.
- sb addr=0x203, wdata=0x000000A5 -> bus_addr=0x200, be=1000, bus_wdata=0xA5A5A5A5.
- lb addr=0x102, bus_rdata=0x12F08000 -> rdata=0xFFFFFFF0; lbu same -> 0x000000F0; lh addr=0x102 -> 0x000012F0.
- lw addr=0x106 -> no bus_req, err=1 and done=1 on cycle 1, rdata=0; swhb=00 store -> same.
- TIMEOUT=4, bus_ready never asserted -> bus_req high 4 cycles then low, err+done pulse, stall released.
- flush during REQ with bus_ready 3 cycles later -> bus_req held until ready, no done/err, rdata unchanged, FSM IDLE; async reset mid-REQ -> all outputs 0 immediately.
